dest_tracker: RTL
=================

DEST_TRACKER -- requirements
Module: dest_tracker

Interface
REQ-001 Parameter ZERO_REG, default 31; register index hardwired to zero (XZR), never tracked as a producer.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 id_valid  input  1  decode-stage instruction is real (0 = bubble).
REQ-005 id_rd  input  5  decode-stage destination register.
REQ-006 id_rn  input  5  decode-stage first source register.
REQ-007 id_rm  input  5  decode-stage second source register.
REQ-008 id_uses_rm  input  1  decode-stage instruction reads id_rm (register operand, not immediate).
REQ-009 id_regwrite  input  1  decode-stage instruction writes id_rd.
REQ-010 id_memread  input  1  decode-stage instruction is a load.
REQ-011 flush  input  1  taken branch resolved; kill the decode-stage instruction.
REQ-012 rd_idex, rd_exmem, rd_memwb  output  5 each  destination register held in the ID/EX, EX/MEM and MEM/WB stages.
REQ-013 rw_idex, rw_exmem, rw_memwb  output  1 each  register-write enable for the matching stage.
REQ-014 memread_idex  output  1  ID/EX-stage instruction is a load.
REQ-015 stall  output  1  combinational; hold PC and IF/ID this cycle.
REQ-016 stall_count  output  16  number of stall cycles since reset.

Function
REQ-017 Three register stages (ID/EX, EX/MEM, MEM/WB), each holding {rd, rw, memread}; all advance every cycle, with no enable.
REQ-018 Every stage shall hold a bubble after reset: rd = ZERO_REG, rw = 0, memread = 0.
REQ-019 Normal load into ID/EX: rd = id_rd; rw = id_valid & id_regwrite & (id_rd != ZERO_REG); memread = id_valid & id_memread.
REQ-020 A write to ZERO_REG shall always be recorded with rw = 0, so downstream forwarding never matches XZR.
REQ-021 Shift paths: EX/MEM <= ID/EX and MEM/WB <= EX/MEM, each a one-cycle latency, with no hold or kill on those two stages.
REQ-022 Load-use hazard: hz = memread_idex & rw_idex & id_valid & ((rd_idex == id_rn) | (id_uses_rm & (rd_idex == id_rm))).
REQ-023 stall = hz & ~flush; flush has priority over stall.
REQ-024 When stall = 1, ID/EX shall load a bubble next edge; EX/MEM and MEM/WB still advance.
REQ-025 When flush = 1, ID/EX shall load a bubble next edge regardless of the decode inputs.
REQ-026 A load-use stall lasts exactly one cycle, because the bubble clears memread_idex.
REQ-027 No stall for a dependency on EX/MEM or MEM/WB producers; the forwarding logic covers those cases.
REQ-028 stall_count shall increment by 1 on each edge where stall = 1 and saturate at 0xFFFF (no wrap).
REQ-029 Outputs rd_*, rw_*, memread_idex shall be direct register outputs with no combinational path from the inputs.

Reset
REQ-030 Reset asserted on an edge: all stages become bubbles, stall_count = 0; reset overrides stall and flush in the same cycle.
REQ-031 While reset = 1, stall shall read 0 and the outputs shall show the bubble values; reset de-asserting mid-stream resumes with empty stages.

Verification
REQ-032 ADD x1 (id_rd = 1, regwrite) then NOPs -> rd_idex = 1 / rw_idex = 1 at cycle 1, the EX/MEM copy at cycle 2, the MEM/WB copy at cycle 3, then all rw = 0.
REQ-033 LDUR x2 followed by ADD x3, x2, x4 -> stall = 1 for exactly one cycle, stall_count = 1; the next ID/EX holds a bubble (rw_idex = 0), then the ADD enters with rd_idex = 3.
REQ-034 LDUR x2 followed by ADDI x3, x5, #4 with id_rm = 2 and id_uses_rm = 0 -> no stall; LDUR x31 followed by a use of x31 -> rw_idex = 0, no stall.
REQ-035 Load-use hazard with flush = 1 in the same cycle -> stall = 0, stall_count unchanged, ID/EX bubble next cycle.
REQ-036 Force 70000 consecutive hazard cycles -> stall_count saturates at 0xFFFF; reset pulsed mid-pipeline with three valid writers -> all rw = 0 and stall_count = 0 on the next cycle.

Source files
------------

// File: rtl/dest_tracker.sv
// dest_tracker: destination-register pipeline (ID/EX, EX/MEM, MEM/WB) with load-use stall detection
// Revision 1.0
`default_nettype none

module dest_tracker #(
  parameter int ZERO_REG = 31,
  parameter int COUNT_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               id_valid,
  input  logic [4:0]         id_rd,
  input  logic [4:0]         id_rn,
  input  logic [4:0]         id_rm,
  input  logic               id_uses_rm,
  input  logic               id_regwrite,
  input  logic               id_memread,
  input  logic               flush,
  output logic [4:0]         rd_idex,
  output logic [4:0]         rd_exmem,
  output logic [4:0]         rd_memwb,
  output logic               rw_idex,
  output logic               rw_exmem,
  output logic               rw_memwb,
  output logic               memread_idex,
  output logic               stall,
  output logic [COUNT_W-1:0] stall_count
);

  localparam logic [4:0] XZR = 5'(ZERO_REG);

  logic hz;
  logic kill;

  always_comb begin
    hz = memread_idex & rw_idex & id_valid &
         ((rd_idex == id_rn) | (id_uses_rm & (rd_idex == id_rm)));
  end

  // Reset masks stall so it reads 0 while the pipeline is being cleared.
  assign stall = hz & ~flush & ~reset;
  assign kill  = stall | flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_idex      <= XZR;
      rd_exmem     <= XZR;
      rd_memwb     <= XZR;
      rw_idex      <= 1'b0;
      rw_exmem     <= 1'b0;
      rw_memwb     <= 1'b0;
      memread_idex <= 1'b0;
      stall_count  <= '0;
    end else begin
      rd_idex      <= kill ? XZR : id_rd;
      rw_idex      <= ~kill & id_valid & id_regwrite & (id_rd != XZR);
      memread_idex <= ~kill & id_valid & id_memread;
      rd_exmem     <= rd_idex;
      rw_exmem     <= rw_idex;
      rd_memwb     <= rd_exmem;
      rw_memwb     <= rw_exmem;
      if (stall && (stall_count != {COUNT_W{1'b1}})) begin
        stall_count <= stall_count + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
